hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. It sits beside the operand-forwarding logic and covers the cases forwarding cannot resolve: load-use stalls, taken-branch flushes, and multi-cycle data-memory waits with timeout. It drives the per-stage register enables and flushes, and keeps saturating stall and flush performance counters.

## Interface

Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before the access is abandoned; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- rs1_sel_if_id, rs2_sel_if_id  in  5  source registers of the instruction in IF/ID
- rs1_used, rs2_used  in  1  source operand actually read by the IF/ID instruction
- rs2_store_only  in  1  IF/ID is a store whose rs2 is store data only
- rd_sel_id_ex  in  5  destination register in ID/EX
- reg_wr_en_id_ex  in  1  ID/EX writes the register file
- reg_wr_mux_sel_id_ex  in  3  writeback source in ID/EX; 0 = ALU, 1..5 = load variants
- br_taken_ex  in  1  taken branch or jump resolved in EX
- dmem_req  in  1  EX/MEM holds a data-memory access (level)
- dmem_ack  in  1  memory completes the access (1-cycle pulse)
- cnt_clr  in  1  synchronous clear of both counters
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  stage register enables
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  insert a bubble into that stage register
- mem_err  out  1  timeout pulse
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation

- FSM states: RUN, MEM_WAIT. A wait counter wait_cnt (8 bits) runs alongside the FSM.
- All outputs are combinational from the state and the inputs. Counters and wait_cnt are registered.
- Default outputs in RUN with no event: all enables = 1, all flushes = 0, mem_err = 0.
- Load-use hazard (ld_use) is asserted when all of the following hold:
  - reg_wr_en_id_ex = 1
  - reg_wr_mux_sel_id_ex is in 1..5
  - rd_sel_id_ex != 0
  - either (rs1_used and rs1_sel_if_id matches rd_sel_id_ex) or (rs2_used and rs2_sel_if_id matches rd_sel_id_ex and not rs2_store_only)
- A store with rs2_store_only does not stall, because the dmem write-data forwarding path covers it.
- Priority in RUN is memory wait, then branch, then load-use.
  - dmem_req=1 and dmem_ack=0: freeze. pc_en, if_id_en, id_ex_en and ex_mem_en = 0; mem_wb_flush = 1. Next state is MEM_WAIT with wait_cnt=1.
  - dmem_req and dmem_ack in the same cycle: zero-wait access, no stall.
  - br_taken_ex: if_id_flush = 1, id_ex_flush = 1, pc_en = 1. Load-use is ignored because the younger instruction is being flushed.
  - ld_use: pc_en = 0, if_id_en = 0, id_ex_flush = 1. This is a 1-cycle bubble; the condition clears naturally on the next cycle.
- MEM_WAIT:
  - Without ack: outputs are the same freeze as above and wait_cnt increments.
  - dmem_ack=1: release in that cycle with RUN-rule outputs applied (a held br_taken_ex flushes now). Next state is RUN and wait_cnt returns to 0.
  - wait_cnt = MEM_TIMEOUT-1 without ack: mem_err = 1 and pc_en = 0. if_id_flush, id_ex_flush and mem_wb_flush = 1; ex_mem_en = 1. Next state is RUN. A late ack is ignored.
- Counters:
  - stall_cnt increments on every cycle with pc_en = 0.
  - flush_cnt increments on every cycle with if_id_flush = 1.
  - Both saturate at all-ones. cnt_clr takes priority over increment.

## Timing

- Reset values: state RUN, wait_cnt 0, stall_cnt 0, flush_cnt 0. During reset the outputs follow the RUN rules.
- Stall and flush response has 0-cycle latency: the outputs are valid in the same cycle as the triggering inputs.
- Load-use costs exactly 1 bubble cycle.
- A memory wait of N cycles before ack gives N freeze cycles. The ack cycle itself is not frozen.
- A timeout produces exactly MEM_TIMEOUT-1 freeze cycles followed by 1 mem_err cycle.
- Reset asserted in MEM_WAIT returns the block to RUN immediately. wait_cnt clears and no mem_err is generated.
- br_taken_ex arriving during MEM_WAIT is held by the frozen EX stage and acted on in the release cycle.

## Structure

- hazard_pkg holds:
  - the state enum (RUN, MEM_WAIT)
  - writeback-select constants WB_ALU=0, WB_LD_LO=1, WB_LD_HI=5, shared with the forwarding unit
  - the ld_use helper function
- Sub-module sat_counter (parameter W; inputs inc and clr) is instantiated twice.

## Test plan

- Load to x5 in ID/EX, IF/ID add reads rs1=x5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1.
- Load to x0, IF/ID reads x0 -> no stall. Store with rs2=x5 and rs2_store_only=1 after a load to x5 -> no stall.
- dmem_req high with ack in the 4th cycle -> 3 freeze cycles (mem_wb_flush=1), release in the ack cycle; stall_cnt=3.
- MEM_TIMEOUT=4 and no ack -> 3 freeze cycles, then mem_err=1 with all three flushes; late ack ignored; state RUN.
- br_taken_ex together with ld_use -> if_id_flush=id_ex_flush=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- CNT_W=2 with 5 load-use stalls -> stall_cnt saturates at 3. cnt_clr -> 0. rst_n low mid-MEM_WAIT -> RUN, mem_err=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// - state_t        : controller FSM states
// - WB_* constants : writeback-source encodings, also used by the forwarding unit
// - ld_use()       : load-use hazard detect between IF/ID and ID/EX
package hazard_pkg;

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [2:0] WB_ALU   = 3'd0;
   localparam logic [2:0] WB_LD_LO = 3'd1;
   localparam logic [2:0] WB_LD_HI = 3'd5;

   // Store data (rs2 of a store) is covered by dmem write-data forwarding,
   // so it never needs the bubble.
   function automatic logic ld_use(
      input logic [4:0] rs1_sel,
      input logic [4:0] rs2_sel,
      input logic       rs1_used,
      input logic       rs2_used,
      input logic       rs2_store_only,
      input logic [4:0] rd_sel,
      input logic       reg_wr_en,
      input logic [2:0] wb_sel
   );
      logic is_load;
      logic hit1;
      logic hit2;
      is_load = reg_wr_en && (wb_sel >= WB_LD_LO) && (wb_sel <= WB_LD_HI) && (rd_sel != 5'd0);
      hit1    = rs1_used && (rs1_sel == rd_sel);
      hit2    = rs2_used && (rs2_sel == rd_sel) && !rs2_store_only;
      return is_load && (hit1 || hit2);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async low), inc (count enable), clr (sync clear, wins
// over inc), cnt (current value, sticks at all-ones).
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != '1))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / stall controller for the 5-stage core.
// Handles load-use bubbles, taken-branch flushes and data-memory waits with
// timeout; drives stage enables/flushes combinationally and keeps saturating
// stall/flush performance counters.
// Inputs : IF/ID source regs + usage, ID/EX dest/write info, br_taken_ex,
//          dmem_req/dmem_ack, cnt_clr.
// Outputs: pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
//          mem_wb_flush, mem_err, stall_cnt, flush_cnt.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_sel_if_id,
   input  logic [4:0]       rs2_sel_if_id,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic             rs2_store_only,
   input  logic [4:0]       rd_sel_id_ex,
   input  logic             reg_wr_en_id_ex,
   input  logic [2:0]       reg_wr_mux_sel_id_ex,
   input  logic             br_taken_ex,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   input  logic             cnt_clr,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_flush,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state, state_nx;
   logic [7:0] wait_cnt, wait_nx;
   logic       hz_ld;
   logic       freeze;
   logic       run_rules;

   assign hz_ld = ld_use(rs1_sel_if_id, rs2_sel_if_id, rs1_used, rs2_used, rs2_store_only,
                         rd_sel_id_ex, reg_wr_en_id_ex, reg_wr_mux_sel_id_ex);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      wait_nx      = wait_cnt;
      freeze       = 1'b0;
      run_rules    = 1'b0;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      mem_err      = 1'b0;

      case (state)
         RUN: begin
            // req with same-cycle ack is a zero-wait access
            if (dmem_req && !dmem_ack) begin
               freeze   = 1'b1;
               state_nx = MEM_WAIT;
               wait_nx  = 8'd1;
            end else begin
               run_rules = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (dmem_ack) begin
               // release cycle: EX held any branch, act on it now
               run_rules = 1'b1;
               state_nx  = RUN;
               wait_nx   = 8'd0;
            end else if (wait_cnt == WAIT_LAST) begin
               // abandon the access: drain EX/MEM, bubble everything else
               mem_err      = 1'b1;
               pc_en        = 1'b0;
               if_id_flush  = 1'b1;
               id_ex_flush  = 1'b1;
               mem_wb_flush = 1'b1;
               state_nx     = RUN;
               wait_nx      = 8'd0;
            end else begin
               freeze  = 1'b1;
               wait_nx = wait_cnt + 8'd1;
            end
         end
         default: begin
            state_nx = RUN;
            wait_nx  = 8'd0;
         end
      endcase

      if (freeze) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end

      // branch wins over load-use: the dependent younger instr is flushed
      if (run_rules) begin
         if (br_taken_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (hz_ld) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (!pc_en),
      .clr   (cnt_clr),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (if_id_flush),
      .clr   (cnt_clr),
      .cnt   (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int TO    = 4;
   localparam int CW    = 2;
   localparam int SAT   = (1 << CW) - 1;

   logic          clk, rst_n;
   logic [4:0]    rs1, rs2, rd;
   logic          u1, u2, so, wr, br, req, ack, clr;
   logic [2:0]    wbsel;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic          if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int pass_cnt = 0;
   int total    = 0;

   // reference model: "in a memory wait, N cycles waited so far" + counters
   bit m_wait;
   int m_waited;
   int m_stall, m_flush;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1_sel_if_id(rs1), .rs2_sel_if_id(rs2),
      .rs1_used(u1), .rs2_used(u2), .rs2_store_only(so),
      .rd_sel_id_ex(rd), .reg_wr_en_id_ex(wr), .reg_wr_mux_sel_id_ex(wbsel),
      .br_taken_ex(br), .dmem_req(req), .dmem_ack(ack), .cnt_clr(clr),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic idle();
      rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; so = 0; wr = 0; wbsel = 0;
      br = 0; req = 0; ack = 0; clr = 0;
   endtask

   task automatic set_load(input logic [4:0] dst);
      wr = 1; wbsel = 3'd1; rd = dst;
   endtask

   // one clock: check outputs mid-cycle, then advance model and clock
   task automatic cyc();
      logic [7:0] e, o;
      bit ldu, timeout, frz;
      @(negedge clk); #1;
      if (!rst_n) begin
         m_wait = 0; m_waited = 0; m_stall = 0; m_flush = 0;
      end
      ldu = wr && wbsel >= 1 && wbsel <= 5 && rd != 0 &&
            ((u1 && rs1 == rd) || (u2 && rs2 == rd && !so));
      timeout = m_wait && !ack && (m_waited == TO - 1);
      frz     = m_wait ? !ack : (req && !ack);
      // {pc,if_id,id_ex,ex_mem en, if_id,id_ex,mem_wb flush, mem_err}
      if (timeout)  e = 8'b0111_1111;
      else if (frz) e = 8'b0000_0010;
      else if (br)  e = 8'b1111_1100;
      else if (ldu) e = 8'b0011_0100;
      else          e = 8'b1111_0000;
      o = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush, mem_err};
      chk("outputs", 32'(o), 32'(e));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      if (rst_n) begin
         if (clr) begin
            m_stall = 0; m_flush = 0;
         end else begin
            if (!e[7] && m_stall < SAT) m_stall++;
            if (e[3] && m_flush < SAT) m_flush++;
         end
         if (!m_wait) begin
            if (req && !ack) begin m_wait = 1; m_waited = 1; end
         end else if (ack || timeout) begin
            m_wait = 0; m_waited = 0;
         end else begin
            m_waited++;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      idle();
      rst_n = 0;
      cyc();
      rst_n = 1;

      // load-use on rs1: single bubble
      clr = 1; cyc(); idle();
      set_load(5); rs1 = 5; u1 = 1; cyc();
      idle(); cyc();
      chk("ldu_stall_cnt", 32'(stall_cnt), 32'd1);

      // x0 destination and store-data operand never stall
      set_load(0); rs1 = 0; u1 = 1; cyc();
      idle(); set_load(5); rs2 = 5; u2 = 1; so = 1; cyc();
      so = 0; cyc();                      // same operand as real source: stalls
      idle();

      // memory wait with ack in 4th cycle
      clr = 1; cyc(); idle();
      req = 1; cyc(); cyc(); cyc();
      ack = 1; cyc();
      idle(); cyc();
      chk("memwait_stall_cnt", 32'(stall_cnt), 32'd3);

      // timeout: 3 freezes, then mem_err; late ack ignored
      req = 1; cyc(); cyc(); cyc(); cyc();
      req = 0; ack = 1; cyc();
      idle(); cyc();

      // branch masks load-use
      clr = 1; cyc(); idle();
      set_load(7); rs1 = 7; u1 = 1; br = 1; cyc();
      idle(); cyc();
      chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
      chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

      // branch held through a memory wait acts in release cycle
      req = 1; br = 1; cyc(); cyc();
      ack = 1; cyc();
      idle(); cyc();

      // saturation then clear
      clr = 1; cyc(); idle();
      for (int i = 0; i < 5; i++) begin
         set_load(3); rs2 = 3; u2 = 1; cyc();
         idle(); cyc();
      end
      chk("sat_stall_cnt", 32'(stall_cnt), 32'(SAT));
      clr = 1; cyc(); idle();
      chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);

      // reset in the middle of a wait
      req = 1; cyc(); cyc();
      rst_n = 0; cyc();
      chk("rst_mem_err", 32'(mem_err), 32'd0);
      rst_n = 1; idle(); cyc();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rs1   = 5'($urandom_range(0, 3));
         rs2   = 5'($urandom_range(0, 3));
         rd    = 5'($urandom_range(0, 3));
         u1    = 1'($urandom);
         u2    = 1'($urandom);
         so    = ($urandom_range(0, 3) == 0);
         wr    = 1'($urandom);
         wbsel = 3'($urandom_range(0, 7));
         br    = ($urandom_range(0, 3) == 0);
         req   = m_wait ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
         ack   = ($urandom_range(0, 4) == 0);
         clr   = ($urandom_range(0, 31) == 0);
         rst_n = ($urandom_range(0, 63) != 0);
         cyc();
      end
      rst_n = 1; idle(); cyc();

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
